dcache_control: RTL and testbench
=================================

Name: dcache_control

Overview:
- Control FSM for the direct-mapped, write-back data cache. Sits directly upstream of the cache's tag/valid/dirty/data register arrays.
- Arrays use a registered read: output appears 1 cycle after read is asserted, with write-to-read forwarding when the read and write indexes match.
- The block accepts CPU requests, sequences array reads and writes, detects hit or miss, and runs write-back and allocate transactions on physical memory.
- It also keeps saturating hit and miss counters.

Parameters:
s_index, 5, index bits (32 sets)
s_offset, 5, line offset bits (32-byte line)
s_tag, 22, tag bits (32 - s_index - s_offset)
cnt_width, 16, width of hit/miss counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
mem_address  in  32  CPU byte address; sampled in IDLE
mem_read  in  1  CPU read request, level, held until mem_resp
mem_write  in  1  CPU write request, level, held until mem_resp
mem_resp  out  1  1-cycle pulse: request complete
tag_out  in  s_tag  tag array dataout
valid_out  in  1  valid array dataout
dirty_out  in  1  dirty array dataout
array_read  out  1  read strobe to all arrays
rindex  out  s_index  array read index
windex  out  s_index  array write index
tag_load, valid_load, dirty_load, data_load  out  1 each  array write strobes
valid_in, dirty_in  out  1 each  write data for valid/dirty arrays
data_sel  out  1  data-array input mux: 0 = CPU write merge, 1 = pmem line
pmem_read, pmem_write  out  1 each  physical memory request, level
pmem_address  out  32  line-aligned physical address (low s_offset bits = 0)
pmem_resp  in  1  physical memory done, 1-cycle pulse
hit_count, miss_count  out  cnt_width each  saturating event counters

Behaviour:
- Reset (rst=0, async) forces state IDLE. All outputs, counters, latched address and victim tag go to 0. A pmem request in flight is abandoned and pmem_read/pmem_write drop immediately.
- Latched address A is captured in IDLE on request acceptance. idx = A[s_offset+s_index-1:s_offset]; tg = A[31:s_offset+s_index].
- rindex = windex = idx in every state except IDLE, where rindex = current mem_address index.
- Hit is defined as valid_out & (tag_out == tg), evaluated only in LOOKUP.

States:
- IDLE
  - If mem_read | mem_write: array_read=1, latch A, go to LOOKUP. A read and write asserted together are treated as a write.
  - Otherwise stay; all strobes 0.
- LOOKUP (array outputs valid this cycle)
  - Hit, read: mem_resp=1, hit_count+1, go to IDLE.
  - Hit, write: data_load=1, data_sel=0, dirty_load=1, dirty_in=1, mem_resp=1, hit_count+1, go to IDLE.
  - Miss: miss_count+1; latch victim tag vt = tag_out.
    - valid_out & dirty_out: go to WRITEBACK.
    - Otherwise: go to ALLOCATE.
- WRITEBACK
  - pmem_write=1, pmem_address = {vt, idx, 0}.
  - Hold until pmem_resp, then go to ALLOCATE. Deasserting pmem_write in the pmem_resp cycle is permitted.
- ALLOCATE
  - pmem_read=1, pmem_address = {tg, idx, 0}.
  - On pmem_resp: data_load=1, data_sel=1, tag_load=1, valid_load=1, valid_in=1, dirty_load=1, dirty_in=0, array_read=1, go to LOOKUP.
  - Array forwarding guarantees the re-lookup hits. The miss is not counted again; that re-lookup hit does not increment hit_count.
- Latency: read hit 2 cycles from request to mem_resp. Clean miss = 2 + pmem latency + 1. Dirty miss adds one pmem write.
- mem_resp is never asserted outside LOOKUP and never for 2 consecutive cycles.
- pmem_read and pmem_write are never asserted together.
- Counters saturate at all-ones; no wrap.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- mem_address changes after acceptance are ignored until the next IDLE.

Test Plan:
- Reset, then read A=0x0000_0040 (idx 2) to an empty cache → ALLOCATE with pmem_read, pmem_address=0x0000_0040; after pmem_resp, mem_resp 1 cycle later; miss_count=1, hit_count=0.
- Repeat read of 0x0000_0044 → mem_resp exactly 2 cycles after request, no pmem activity, hit_count=1.
- Write 0x0000_0048 (hit) → data_load, dirty_load with dirty_in=1, data_sel=0 in the mem_resp cycle. Then read 0x0000_1040 (same idx, new tag) → pmem_write at 0x0000_0040 first, then pmem_read at 0x0000_1040, then mem_resp.
- Drop rst mid-WRITEBACK, asynchronously between clock edges → pmem_write and counters drop to 0 immediately; after release, first request is a miss in IDLE-to-LOOKUP flow.
- Force miss_count to all-ones via repeated conflicting misses on a cnt_width=2 build → stays 3.
- Spurious pmem_resp pulse in IDLE → no state change, no strobes.

Source files
------------

// File: rtl/dcache_control.sv
// dcache_control: control FSM for a direct-mapped, write-back data cache.
// It takes CPU requests and drives the tag/valid/dirty/data arrays. It detects
// hit or miss, and on a miss writes back a dirty victim line and then
// allocates the new line from physical memory. It also keeps saturating
// hit and miss counters.
//
// Ports:
//   clk, rst             clock (rising edge); asynchronous active-low reset
//   mem_address          CPU byte address, sampled when a request is accepted
//   mem_read, mem_write  CPU request levels, held until mem_resp
//   mem_resp             one-cycle completion pulse
//   tag_out, valid_out, dirty_out   array read data (registered read)
//   array_read, rindex, windex      array read strobe and read/write indexes
//   tag_load, valid_load, dirty_load, data_load, valid_in, dirty_in, data_sel
//                        array write strobes and write data (data_sel: 0 = CPU
//                        merge, 1 = pmem line)
//   pmem_read, pmem_write, pmem_address, pmem_resp   physical memory handshake
//   hit_count, miss_count  saturating event counters
module dcache_control #(
  parameter int s_index   = 5,
  parameter int s_offset  = 5,
  parameter int s_tag     = 22,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_address,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic [s_tag-1:0]     tag_out,
  input  logic                 valid_out,
  input  logic                 dirty_out,
  output logic                 array_read,
  output logic [s_index-1:0]   rindex,
  output logic [s_index-1:0]   windex,
  output logic                 tag_load,
  output logic                 valid_load,
  output logic                 dirty_load,
  output logic                 data_load,
  output logic                 valid_in,
  output logic                 dirty_in,
  output logic                 data_sel,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  input  logic                 pmem_resp,
  output logic [cnt_width-1:0] hit_count,
  output logic [cnt_width-1:0] miss_count
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOOKUP    = 2'd1;
  localparam logic [1:0] WRITEBACK = 2'd2;
  localparam logic [1:0] ALLOCATE  = 2'd3;

  localparam int ALEN = 32 - s_offset;

  logic [1:0]           state_q, state_d;
  logic [ALEN-1:0]      addr_q;     // line address of the accepted request
  logic [s_tag-1:0]     vt_q;       // victim tag captured on a miss
  logic                 wr_q;       // accepted request is a write
  logic                 refill_q;   // current LOOKUP is the post-allocate re-lookup
  logic [cnt_width-1:0] hit_cnt_q, miss_cnt_q;

  logic [s_index-1:0]   idx;
  logic [s_tag-1:0]     tg;
  logic                 req, hit, hit_inc, miss_inc;
  logic                 unused;

  assign idx    = addr_q[s_index-1:0];
  assign tg     = addr_q[ALEN-1:s_index];
  assign req    = mem_read | mem_write;
  assign hit    = valid_out & (tag_out == tg);
  assign unused = &{1'b0, mem_address[s_offset-1:0]};

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    array_read   = 1'b0;
    rindex       = '0;
    windex       = '0;
    tag_load     = 1'b0;
    valid_load   = 1'b0;
    dirty_load   = 1'b0;
    data_load    = 1'b0;
    valid_in     = 1'b0;
    dirty_in     = 1'b0;
    data_sel     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    // Outputs are held at zero while reset is asserted, even though some of
    // them (IDLE read strobe/index) would otherwise follow the CPU inputs.
    if (rst) begin
      rindex = idx;
      windex = idx;
      case (state_q)
        IDLE: begin
          rindex = mem_address[s_offset+s_index-1:s_offset];
          if (req) begin
            array_read = 1'b1;
            state_d    = LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            mem_resp = 1'b1;
            hit_inc  = ~refill_q;
            if (wr_q) begin
              data_load  = 1'b1;
              dirty_load = 1'b1;
              dirty_in   = 1'b1;
            end
            state_d = IDLE;
          end else begin
            miss_inc = ~refill_q;
            state_d  = (valid_out & dirty_out) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          pmem_write   = 1'b1;
          pmem_address = {vt_q, idx, {s_offset{1'b0}}};
          if (pmem_resp) state_d = ALLOCATE;
        end
        default: begin  // ALLOCATE
          pmem_read    = 1'b1;
          pmem_address = {tg, idx, {s_offset{1'b0}}};
          if (pmem_resp) begin
            // Fill the line and re-read it; write forwarding in the arrays
            // makes the following LOOKUP see the new line.
            data_load  = 1'b1;
            data_sel   = 1'b1;
            tag_load   = 1'b1;
            valid_load = 1'b1;
            valid_in   = 1'b1;
            dirty_load = 1'b1;
            array_read = 1'b1;
            state_d    = LOOKUP;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      vt_q       <= '0;
      wr_q       <= 1'b0;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        addr_q   <= mem_address[31:s_offset];
        wr_q     <= mem_write;
        refill_q <= 1'b0;
      end
      if (state_q == LOOKUP && !hit) vt_q <= tag_out;
      if (state_q == ALLOCATE && pmem_resp) refill_q <= 1'b1;
      if (hit_inc && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + cnt_width'(1);
      if (miss_inc && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + cnt_width'(1);
    end
  end

endmodule

// File: tb/tb_dcache_control.sv
// Bench for dcache_control. Surrounds the DUT with a tag/valid/dirty array
// model (registered read with write forwarding) and a fixed-latency physical
// memory. A second instance with 2-bit counters shares every input so counter
// saturation can be observed. Expected behaviour comes from a set-level cache
// model plus the request/latency rules; a per-cycle compare process checks
// the outputs against those rules.
module tb_dcache_control;
  localparam int PL = 3;  // pmem latency in cycles

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_address = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic        mem_resp;
  logic [21:0] tag_out = '0;
  logic        valid_out = 1'b0, dirty_out = 1'b0;
  logic        array_read;
  logic [4:0]  rindex, windex;
  logic        tag_load, valid_load, dirty_load, data_load, valid_in, dirty_in, data_sel;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address;
  logic        pm_resp = 1'b0, spur = 1'b0, pmem_resp;
  logic [15:0] hit_count, miss_count;

  // second instance: only counters are observed
  logic        s_mem_resp, s_array_read, s_tag_load, s_valid_load, s_dirty_load;
  logic        s_data_load, s_valid_in, s_dirty_in, s_data_sel, s_pmem_read, s_pmem_write;
  logic [4:0]  s_rindex, s_windex;
  logic [31:0] s_pmem_address;
  logic [1:0]  hit2, miss2;

  assign pmem_resp = pm_resp | spur;

  always #5 clk = ~clk;

  dcache_control dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_resp(mem_resp), .tag_out(tag_out),
    .valid_out(valid_out), .dirty_out(dirty_out), .array_read(array_read),
    .rindex(rindex), .windex(windex), .tag_load(tag_load), .valid_load(valid_load),
    .dirty_load(dirty_load), .data_load(data_load), .valid_in(valid_in),
    .dirty_in(dirty_in), .data_sel(data_sel), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count));

  dcache_control #(.cnt_width(2)) dut2 (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_resp(s_mem_resp), .tag_out(tag_out),
    .valid_out(valid_out), .dirty_out(dirty_out), .array_read(s_array_read),
    .rindex(s_rindex), .windex(s_windex), .tag_load(s_tag_load),
    .valid_load(s_valid_load), .dirty_load(s_dirty_load), .data_load(s_data_load),
    .valid_in(s_valid_in), .dirty_in(s_dirty_in), .data_sel(s_data_sel),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
    .pmem_address(s_pmem_address), .pmem_resp(pmem_resp),
    .hit_count(hit2), .miss_count(miss2));

  // ---------------- environment: arrays and physical memory ----------------
  logic [21:0] cur_tag = '0;  // tag of the request in flight (tag array datain)
  logic [21:0] tag_arr [32] = '{default: '0};
  logic        valid_arr [32] = '{default: 1'b0};
  logic        dirty_arr [32] = '{default: 1'b0};

  always @(posedge clk) begin
    if (array_read) begin
      tag_out   <= (tag_load   && windex == rindex) ? cur_tag  : tag_arr[rindex];
      valid_out <= (valid_load && windex == rindex) ? valid_in : valid_arr[rindex];
      dirty_out <= (dirty_load && windex == rindex) ? dirty_in : dirty_arr[rindex];
    end
    if (tag_load)   tag_arr[windex]   <= cur_tag;
    if (valid_load) valid_arr[windex] <= valid_in;
    if (dirty_load) dirty_arr[windex] <= dirty_in;
  end

  int pcnt = 0;
  always @(posedge clk) begin
    #2;
    pm_resp = 1'b0;
    if (!rst) pcnt = 0;
    else if (pmem_read || pmem_write) begin
      pcnt++;
      if (pcnt == PL) begin
        pm_resp = 1'b1;
        pcnt = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int vectors = 0, miscompares = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // set-level cache model
  logic [21:0] mtag [32] = '{default: '0};
  bit          mvalid [32] = '{default: 1'b0};
  bit          mdirty [32] = '{default: 1'b0};
  int          mhits = 0, mmiss = 0;

  // expectations for the request in flight
  bit          active = 1'b0, resp_seen = 1'b0;
  int          cyc = 0, exp_lat = 0, last_lat = 0;
  bit          exp_wb = 1'b0, exp_miss = 1'b0, exp_wr = 1'b0;
  logic [4:0]  exp_idx = '0;
  logic [31:0] exp_wb_addr = '0, exp_al_addr = '0, last_rd_addr = '0, last_wr_addr = '0;

  always @(negedge clk) begin
    if (rst && active) begin
      automatic int  wbl   = exp_wb ? PL : 0;
      automatic bit  e_wb  = exp_wb && cyc >= 3 && cyc <= 2 + PL;
      automatic bit  e_rd  = exp_miss && cyc >= 3 + wbl && cyc <= 2 + wbl + PL;
      automatic bit  e_rsp = (cyc == exp_lat);
      automatic bit  e_ref = exp_miss && cyc == 2 + wbl + PL;
      automatic bit  e_wm  = e_rsp && exp_wr;
      chk("pmem_write", pmem_write, e_wb);
      chk("pmem_read", pmem_read, e_rd);
      chk("mem_resp", mem_resp, e_rsp);
      chk("array_read", array_read, cyc == 1 || e_ref);
      chk("data_load", data_load, e_ref || e_wm);
      chk("dirty_load", dirty_load, e_ref || e_wm);
      chk("dirty_in", dirty_in, e_wm);
      chk("data_sel", data_sel, e_ref);
      chk("tag_load", tag_load, e_ref);
      chk("valid_load", valid_load, e_ref);
      chk("valid_in", valid_in, e_ref);
      chk("rindex", rindex, exp_idx);
      if (cyc >= 2) chk("windex", windex, exp_idx);
      if (pmem_write) begin
        last_wr_addr = pmem_address;
        if (e_wb) chk("wb_addr", pmem_address, exp_wb_addr);
      end
      if (pmem_read) begin
        last_rd_addr = pmem_address;
        if (e_rd) chk("al_addr", pmem_address, exp_al_addr);
      end
      if (mem_resp) begin
        resp_seen = 1'b1;
        last_lat  = cyc;
      end
    end else if (rst) begin
      chk("idle_mem_resp", mem_resp, 0);
      chk("idle_pmem", {pmem_read, pmem_write}, 0);
      chk("idle_array_read", array_read, 0);
      chk("idle_loads", {tag_load, valid_load, dirty_load, data_load}, 0);
    end
  end

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One CPU request. abort_cyc != 0 drops reset mid-cycle at that cycle.
  task automatic do_req(input logic [31:0] a, input bit rd, input bit wr, input int abort_cyc);
    automatic logic [4:0]  i   = a[9:5];
    automatic logic [21:0] t   = a[31:10];
    automatic bit          h   = mvalid[i] && mtag[i] == t;
    automatic bit          dty = !h && mvalid[i] && mdirty[i];
    exp_idx     = i;
    exp_miss    = !h;
    exp_wb      = dty;
    exp_wr      = wr;
    exp_wb_addr = {mtag[i], i, 5'b0};
    exp_al_addr = {t, i, 5'b0};
    exp_lat     = h ? 2 : (dty ? 3 + 2 * PL : 3 + PL);
    resp_seen   = 1'b0;
    @(posedge clk); #1;
    mem_address = a; mem_read = rd; mem_write = wr; cur_tag = t;
    cyc = 1; active = 1'b1;
    while (!resp_seen && cyc <= exp_lat + 4) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) mem_address = ~a;  // must be ignored after acceptance
      if (abort_cyc != 0 && cyc == abort_cyc) begin
        #2;
        chk("pre_abort_pmem_write", pmem_write, 1);
        active = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_pmem_write", pmem_write, 0);
        chk("abort_pmem_read", pmem_read, 0);
        chk("abort_hit_count", hit_count, 0);
        chk("abort_miss_count", miss_count, 0);
        chk("abort_mem_resp", mem_resp, 0);
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1;
        mhits = 0; mmiss = 0;
        return;
      end
    end
    active = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    if (!resp_seen) chk("resp_timeout", 0, 1);
    if (h) mhits++; else mmiss++;
    mtag[i] = t; mvalid[i] = 1'b1;
    if (wr) mdirty[i] = 1'b1; else if (!h) mdirty[i] = 1'b0;
    chk("hit_count", hit_count, sat(mhits, 65535));
    chk("miss_count", miss_count, sat(mmiss, 65535));
    chk("hit_count_w2", hit2, sat(mhits, 3));
    chk("miss_count_w2", miss2, sat(mmiss, 3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset with a request pending: outputs must stay quiet
    mem_read = 1'b1; mem_address = 32'h0000_0040;
    repeat (2) @(posedge clk);
    #7;
    chk("rst_array_read", array_read, 0);
    chk("rst_hit", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_pmem", {pmem_read, pmem_write, mem_resp}, 0);
    chk("rst_rindex", rindex, 0);
    mem_read = 1'b0;
    @(posedge clk); #3; rst = 1'b1;

    do_req(32'h0000_0040, 1, 0, 0);  // clean miss
    chk("lit_miss_lat", last_lat, 6);
    chk("lit_miss_addr", last_rd_addr, 32'h0000_0040);
    chk("lit_miss_cnt", miss_count, 1);
    chk("lit_hit_cnt0", hit_count, 0);

    do_req(32'h0000_0044, 1, 0, 0);  // read hit
    chk("lit_hit_lat", last_lat, 2);
    chk("lit_hit_cnt1", hit_count, 1);

    do_req(32'h0000_0048, 0, 1, 0);  // write hit -> dirty
    chk("lit_whit_lat", last_lat, 2);

    do_req(32'h0000_1040, 1, 0, 0);  // dirty conflict miss
    chk("lit_dirty_lat", last_lat, 9);
    chk("lit_wb_addr", last_wr_addr, 32'h0000_0040);
    chk("lit_al_addr2", last_rd_addr, 32'h0000_1040);

    do_req(32'h0000_1048, 1, 1, 0);  // read+write together = write

    // spurious pmem_resp while idle
    @(posedge clk); #1; spur = 1'b1;
    @(posedge clk); #1; spur = 1'b0;
    repeat (2) @(posedge clk);
    do_req(32'h0000_1044, 1, 0, 0);
    chk("lit_spur_hit_lat", last_lat, 2);

    // reset in the middle of a write-back
    do_req(32'h0000_0040, 1, 0, 4);
    repeat (2) @(posedge clk);
    do_req(32'h0000_0040, 1, 0, 0);  // victim still dirty: full write-back again
    chk("lit_post_rst_miss", miss_count, 1);
    chk("lit_post_rst_hit", hit_count, 0);
    chk("lit_post_rst_lat", last_lat, 9);

    // write miss, then dirty eviction of that line
    do_req(32'h0000_2060, 0, 1, 0);
    do_req(32'h0000_3060, 1, 0, 0);
    chk("lit_wmiss_wb_addr", last_wr_addr, 32'h0000_2060);

    // conflicting clean misses to saturate the 2-bit counter
    do_req(32'h0000_1040, 1, 0, 0);
    do_req(32'h0000_0040, 1, 0, 0);
    do_req(32'h0000_1040, 1, 0, 0);
    chk("lit_sat_miss2", miss2, 2'd3);
    do_req(32'h0000_0040, 1, 0, 0);
    chk("lit_sat_miss2b", miss2, 2'd3);
    do_req(32'h0000_0044, 1, 0, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
